// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Covers width codes, the FSM state encoding, byte-enable generation and load extension.
package dmem_pkg;

  localparam logic [1:0] WIDTH_B = 2'b00;
  localparam logic [1:0] WIDTH_H = 2'b01;
  localparam logic [1:0] WIDTH_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [3:0] byte_en(input logic [1:0] width, input logic [1:0] off);
    case (width)
      WIDTH_B: byte_en = 4'b0001 << off;
      WIDTH_H: byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Store data is replicated so every candidate lane already carries the right bits.
  function automatic logic [31:0] store_data(input logic [1:0] width, input logic [31:0] wdata);
    case (width)
      WIDTH_B: store_data = {4{wdata[7:0]}};
      WIDTH_H: store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] width, input logic uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (width)
      WIDTH_B: load_extend = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      WIDTH_H: load_extend = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the load/store stage (master) and the responder (slave).
interface dmem_responder_if;
  logic        i_ReqValid_1;
  logic        o_ReqReady_1;
  logic [31:0] i_ReqAddr_32;
  logic        i_ReqWe_1;
  logic [1:0]  i_ReqWidth_2;
  logic        i_ReqUnsigned_1;
  logic [31:0] i_ReqWData_32;
  logic        o_RespValid_1;
  logic        i_RespReady_1;
  logic [31:0] o_RespData_32;
  logic        o_RespErr_1;

  modport master (
    output i_ReqValid_1, i_ReqAddr_32, i_ReqWe_1, i_ReqWidth_2, i_ReqUnsigned_1,
           i_ReqWData_32, i_RespReady_1,
    input  o_ReqReady_1, o_RespValid_1, o_RespData_32, o_RespErr_1
  );

  modport slave (
    input  i_ReqValid_1, i_ReqAddr_32, i_ReqWe_1, i_ReqWidth_2, i_ReqUnsigned_1,
           i_ReqWData_32, i_RespReady_1,
    output o_ReqReady_1, o_RespValid_1, o_RespData_32, o_RespErr_1
  );
endinterface

// File: rtl/dmem_bank.sv
// Word-wide data store with a byte-enable synchronous write port and a registered read port.
// The contents are not cleared by reset.
module dmem_bank #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = 12
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_data_d, rd_data_q;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// Timed, handshaked data-memory target: one request at a time, programmable wait states.
// state | meaning
// IDLE  | ready for a request; stores commit on the acceptance edge
// WAIT  | counting wait states down to zero
// RESP  | response held until the core accepts it
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  dmem_responder_if.slave bus
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES - 1);

  state_e          state_d, state_q;
  logic [3:0]      cnt_d, cnt_q;
  logic [1:0]      off_d, off_q;
  logic [1:0]      width_d, width_q;
  logic            uns_d, uns_q;
  logic            we_d, we_q;
  logic            err_d, err_q;
  logic [AW-1:0]   idx_d, idx_q;

  logic            accept;
  logic            req_err;
  logic [AW-1:0]   req_idx;
  logic            wr_en;
  logic            rd_en;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     rd_data;

  assign accept  = (state_q == ST_IDLE) && bus.i_ReqValid_1;
  assign req_idx = bus.i_ReqAddr_32[AW+1:2];

  always_comb begin
    req_err = 1'b0;
    if (bus.i_ReqWidth_2 == 2'b11) req_err = 1'b1;
    if ((bus.i_ReqWidth_2 == WIDTH_H) && bus.i_ReqAddr_32[0]) req_err = 1'b1;
    if ((bus.i_ReqWidth_2 == WIDTH_W) && (bus.i_ReqAddr_32[1:0] != 2'b00)) req_err = 1'b1;
    if ({1'b0, bus.i_ReqAddr_32} >= ADDR_LIMIT) req_err = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    width_d = width_q;
    uns_d   = uns_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          off_d   = bus.i_ReqAddr_32[1:0];
          width_d = bus.i_ReqWidth_2;
          uns_d   = bus.i_ReqUnsigned_1;
          we_d    = bus.i_ReqWe_1;
          err_d   = req_err;
          idx_d   = req_idx;
          if (!req_err && (WAIT_CYCLES > 0)) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (bus.i_RespReady_1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      off_q   <= 2'd0;
      width_q <= WIDTH_B;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      width_q <= width_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  // Loads read on the edge entering RESP; with no wait states that is the acceptance edge.
  assign wr_en  = accept && bus.i_ReqWe_1 && !req_err && !rst;
  assign rd_en  = !rst && (state_d == ST_RESP) && (state_q != ST_RESP) && !we_d && !err_d;
  assign rd_idx = (state_q == ST_IDLE) ? req_idx : idx_q;

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bank (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_be  (byte_en(bus.i_ReqWidth_2, bus.i_ReqAddr_32[1:0])),
    .wr_idx (req_idx),
    .wr_data(store_data(bus.i_ReqWidth_2, bus.i_ReqWData_32)),
    .rd_en  (rd_en),
    .rd_idx (rd_idx),
    .rd_data(rd_data)
  );

  assign bus.o_ReqReady_1  = (state_q == ST_IDLE);
  assign bus.o_RespValid_1 = (state_q == ST_RESP);
  assign bus.o_RespErr_1   = (state_q == ST_RESP) && err_q;
  assign bus.o_RespData_32 = ((state_q == ST_RESP) && !err_q && !we_q)
                             ? load_extend(rd_data, off_q, width_q, uns_q) : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with a single wait state and one with none,
// sharing a request driver selected by sel.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [1:0]  req_width = WIDTH_W;
  logic        req_uns = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready = 1'b1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if if_a ();
  dmem_responder_if if_b ();

  assign if_a.i_ReqValid_1    = req_valid & ~sel;
  assign if_b.i_ReqValid_1    = req_valid & sel;
  assign if_a.i_ReqAddr_32    = req_addr;
  assign if_b.i_ReqAddr_32    = req_addr;
  assign if_a.i_ReqWe_1       = req_we;
  assign if_b.i_ReqWe_1       = req_we;
  assign if_a.i_ReqWidth_2    = req_width;
  assign if_b.i_ReqWidth_2    = req_width;
  assign if_a.i_ReqUnsigned_1 = req_uns;
  assign if_b.i_ReqUnsigned_1 = req_uns;
  assign if_a.i_ReqWData_32   = req_wdata;
  assign if_b.i_ReqWData_32   = req_wdata;
  assign if_a.i_RespReady_1   = resp_ready;
  assign if_b.i_RespReady_1   = resp_ready;

  logic        ready_m, valid_m, err_m;
  logic [31:0] data_m;
  assign ready_m = sel ? if_b.o_ReqReady_1  : if_a.o_ReqReady_1;
  assign valid_m = sel ? if_b.o_RespValid_1 : if_a.o_RespValid_1;
  assign err_m   = sel ? if_b.o_RespErr_1   : if_a.o_RespErr_1;
  assign data_m  = sel ? if_b.o_RespData_32 : if_a.o_RespData_32;

  dmem_responder #(.DEPTH_WORDS(4096), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave)
  );
  dmem_responder #(.DEPTH_WORDS(4096), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, want);
  endtask

  // Full transaction; lat counts negedges from acceptance until RespValid is seen.
  task automatic do_req(input logic s, input logic we, input logic [1:0] w, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] d, output logic e, output int lat);
    int   tmo;
    logic seen;
    @(negedge clk);
    sel = s; req_we = we; req_width = w; req_uns = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    tmo = 0;
    while (!ready_m && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      seen = valid_m;
    end
    chk("resp_seen", {31'b0, seen}, 32'd1);
    d = data_m;
    e = err_m;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] d;
  logic        e;
  int          lat;
  int          acc0;
  int          tmo;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready",   {31'b0, if_a.o_ReqReady_1},  32'd1);
    chk("rst_valid",   {31'b0, if_a.o_RespValid_1}, 32'd0);
    chk("rst_data",    if_a.o_RespData_32,          32'd0);
    chk("rst_err",     {31'b0, if_a.o_RespErr_1},   32'd0);
    chk("rst_ready_b", {31'b0, if_b.o_ReqReady_1},  32'd1);

    // Word store then load, one wait state
    do_req(0, 1, WIDTH_W, 0, 32'h10, 32'hDEADBEEF, d, e, lat);
    chk("st_w_lat", 32'(lat), 32'd2);
    chk("st_w_data", d, 32'd0);
    do_req(0, 0, WIDTH_W, 0, 32'h10, 32'h0, d, e, lat);
    chk("ld_w_data", d, 32'hDEADBEEF);
    chk("ld_w_lat", 32'(lat), 32'd2);
    chk("ld_w_err", {31'b0, e}, 32'd0);

    // Byte store into lane 3, then extensions
    do_req(0, 1, WIDTH_B, 0, 32'h13, 32'h00000080, d, e, lat);
    do_req(0, 0, WIDTH_B, 0, 32'h13, 32'h0, d, e, lat);
    chk("ld_b_signed", d, 32'hFFFFFF80);
    do_req(0, 0, WIDTH_B, 1, 32'h13, 32'h0, d, e, lat);
    chk("ld_b_unsigned", d, 32'h00000080);
    do_req(0, 0, WIDTH_W, 0, 32'h10, 32'h0, d, e, lat);
    chk("ld_w_merged", d, 32'h80ADBEEF);
    do_req(0, 0, WIDTH_H, 0, 32'h12, 32'h0, d, e, lat);
    chk("ld_h_signed", d, 32'hFFFF80AD);

    // Misaligned half and out-of-range store
    do_req(0, 0, WIDTH_H, 0, 32'h11, 32'h0, d, e, lat);
    chk("misal_err", {31'b0, e}, 32'd1);
    chk("misal_lat", 32'(lat), 32'd1);
    chk("misal_data", d, 32'd0);
    do_req(0, 1, WIDTH_W, 0, 32'h0, 32'hA5A5A5A5, d, e, lat);
    do_req(0, 1, WIDTH_W, 0, 32'h4000, 32'hFFFFFFFF, d, e, lat);
    chk("oor_err", {31'b0, e}, 32'd1);
    chk("oor_lat", 32'(lat), 32'd1);
    do_req(0, 0, WIDTH_W, 0, 32'h0, 32'h0, d, e, lat);
    chk("oor_nowrite", d, 32'hA5A5A5A5);
    do_req(0, 0, WIDTH_W, 1, 32'h12, 32'h0, d, e, lat);
    chk("misal_w_err", {31'b0, e}, 32'd1);
    do_req(0, 0, 2'b11, 0, 32'h10, 32'h0, d, e, lat);
    chk("width_err", {31'b0, e}, 32'd1);

    // Backpressure: response held, competing store must be ignored
    do_req(0, 1, WIDTH_W, 0, 32'h20, 32'h12345678, d, e, lat);
    @(negedge clk);
    sel = 0; resp_ready = 1'b0;
    req_we = 0; req_width = WIDTH_W; req_uns = 0; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    tmo = 0;
    while (!valid_m && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    req_we = 1; req_addr = 32'h20; req_wdata = 32'h11111111; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, valid_m}, 32'd1);
      chk("hold_data",  data_m,           32'h80ADBEEF);
      chk("hold_ready", {31'b0, ready_m}, 32'd0);
    end
    resp_ready = 1'b1;
    req_we = 0; req_addr = 32'h20;
    @(posedge clk);
    @(negedge clk);
    chk("rel_ready", {31'b0, ready_m}, 32'd1);
    chk("rel_valid", {31'b0, valid_m}, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!valid_m && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("rel_next_lat", 32'(lat), 32'd2);
    chk("ignored_store", data_m, 32'h12345678);
    @(posedge clk);
    #1;

    // Reset during the wait state of a load
    do_req(0, 1, WIDTH_W, 0, 32'h30, 32'hCAFEF00D, d, e, lat);
    @(negedge clk);
    req_we = 0; req_addr = 32'h30; req_width = WIDTH_W; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_valid", {31'b0, if_a.o_RespValid_1}, 32'd0);
    chk("rstw_ready", {31'b0, if_a.o_ReqReady_1},  32'd1);
    rst = 1'b0;
    do_req(0, 0, WIDTH_W, 0, 32'h30, 32'h0, d, e, lat);
    chk("rstw_keep", d, 32'hCAFEF00D);

    // Zero-wait instance: back-to-back accesses every 2 cycles
    do_req(1, 1, WIDTH_W, 0, 32'h0, 32'h11223344, d, e, lat);
    do_req(1, 1, WIDTH_W, 0, 32'h4, 32'h55667788, d, e, lat);
    do_req(1, 0, WIDTH_W, 0, 32'h0, 32'h0, d, e, lat);
    acc0 = acc_cyc;
    chk("b_ld0", d, 32'h11223344);
    chk("b_lat", 32'(lat), 32'd1);
    do_req(1, 0, WIDTH_W, 0, 32'h4, 32'h0, d, e, lat);
    chk("b_ld1", d, 32'h55667788);
    chk("b_spacing", 32'(acc_cyc - acc0), 32'd2);
    do_req(1, 0, WIDTH_H, 1, 32'h6, 32'h0, d, e, lat);
    chk("b_ld_h_u", d, 32'h00005566);
    do_req(1, 0, WIDTH_B, 0, 32'h7, 32'h0, d, e, lat);
    chk("b_ld_b_s", d, 32'h00000055);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-access port: accepts one load/store request at a time over a valid/ready handshake and returns a response after a programmable number of wait states. Performs byte-lane steering, byte-enable writes, load sign/zero extension and alignment/range checks. Sits between the load/store stage and a synchronous word-wide data store, replacing the zero-latency combinational data RAM with a timed, handshaked target.

## Interface
Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 1: wait states between acceptance and response, 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset, sampled on rising clk
- i_ReqValid_1  in  1  request valid
- o_ReqReady_1  out  1  request ready
- i_ReqAddr_32  in  32  byte address
- i_ReqWe_1  in  1  1 = store, 0 = load
- i_ReqWidth_2  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_ReqUnsigned_1  in  1  zero-extend load (ignored for word and store)
- i_ReqWData_32  in  32  store data, right-aligned
- o_RespValid_1  out  1  response valid
- i_RespReady_1  in  1  response accepted by core
- o_RespData_32  out  32  extended load data; 0 for stores and errors
- o_RespErr_1  out  1  misaligned, out-of-range or illegal width

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: o_ReqReady_1=1. On i_ReqValid_1 & o_ReqReady_1: latch request; go to WAIT if WAIT_CYCLES>0 and no error, else RESP.
- WAIT: counter loads WAIT_CYCLES-1 at acceptance, decrements each cycle; at 0 go to RESP.
- RESP: o_RespValid_1=1; response held stable until i_RespReady_1; then IDLE. o_ReqReady_1=0 in WAIT and RESP (no new request accepted in the release cycle).
- Error: width 11, half with addr[0]=1, word with addr[1:0]!=0, or addr >= 4*DEPTH_WORDS. Errored request performs no write, skips WAIT, response data 0, o_RespErr_1=1.
- Store: byte lanes = byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111; data replicated (byte x4, half x2) so lane selection picks correct bits. Write commits at the acceptance edge.
- Load: word read at the edge entering RESP; lane selected by latched addr[1:0]; byte/half sign-extended unless i_ReqUnsigned_1.
- Word index = addr[2+log2(DEPTH_WORDS)-1:2].

## Timing
- Reset values: o_ReqReady_1=1 (IDLE), o_RespValid_1=0, o_RespData_32=0, o_RespErr_1=0, counter 0, state IDLE. Memory contents not cleared.
- Request accepted at edge N: o_RespValid_1 high from cycle N+1+WAIT_CYCLES (N+1 for errors or WAIT_CYCLES=0).
- Back-to-back: response released at edge M, next request acceptable at edge M+1. Minimum 2-cycle throughput.
- Store followed by load to same word returns new data.
- rst asserted in any state: next cycle IDLE, response dropped; a store already accepted stays committed.
- Inputs other than handshake are don't-care outside acceptance cycle.

## Structure
- Package dmem_pkg: width codes (WIDTH_B/H/W), FSM state enum, byte-enable and load-extend functions.
- Sub-module dmem_bank: DEPTH_WORDS x 32 array, 4-bit byte-enable synchronous write, synchronous read; no reset.
- dmem_responder: FSM, wait counter, request latch, checks, lane steering.

## Test plan
- Reset then word store 0xDEADBEEF to 0x10, load word 0x10 (WAIT_CYCLES=1) -> RespData 0xDEADBEEF, RespValid at acceptance+2, Err 0.
- Byte store 0x80 to 0x13, signed byte load 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word load 0x10 -> 0x80ADBEEF.
- Half load 0x11 -> Err 1 at acceptance+1, data 0; word store to 0x4*DEPTH_WORDS -> Err 1, memory unchanged on readback.
- Hold i_RespReady_1=0 for 5 cycles -> RespValid/RespData stable, ReqReady 0, new ReqValid ignored; release -> next request accepted the following edge.
- WAIT_CYCLES=0 instance: back-to-back loads -> response every 2 cycles, correct data.
- rst asserted during WAIT of a load -> next cycle IDLE, RespValid 0, ReqReady 1; prior stored data intact.
